// File: rtl/pixel_writer.sv
// Streams 24-bit RGB pixels into a double-buffered, bit-plane organised frame store.
// Rows in the top half of the panel go to lane 1 and rows in the bottom half go to lane 0.
module pixel_writer #(
  parameter int unsigned N_ROWS_MAX     = 64,
  parameter int unsigned N_COLS_MAX     = 256,
  parameter int unsigned BITDEPTH_MAX   = 8,
  parameter int unsigned CTRL_REG_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH     = $clog2(N_ROWS_MAX * N_COLS_MAX) - 1
) (
  input  logic                        clk,
  input  logic                        ctrl_rst,
  input  logic                        ctrl_en,
  input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0]   ctrl_n_cols,
  input  logic [CTRL_REG_WIDTH-1:0]   ctrl_bitdepth,
  input  logic [23:0]                 s_pixel,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic                        s_sof,
  input  logic                        s_eol,
  input  logic                        rd_buffer,
  output logic                        wr_en,
  output logic                        wr_buffer,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [1:0]                  wr_be,
  output logic [3*BITDEPTH_MAX-1:0]   wr_data,
  output logic                        status_overrun,
  output logic                        status_sync_err,
  output logic                        frame_done
);

  localparam logic [CTRL_REG_WIDTH-1:0] One = 1;

  typedef enum logic [1:0] {StIdle, StWrite, StHandoff} state_e;

  state_e                      state_q, state_d;
  logic [CTRL_REG_WIDTH-1:0]   n_rows_q, n_rows_d, n_cols_q, n_cols_d, bitdepth_q, bitdepth_d;
  logic [CTRL_REG_WIDTH-1:0]   row_q, row_d, col_q, col_d;
  logic                        wr_buffer_q, wr_buffer_d;
  logic                        wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]       wr_addr_q, wr_addr_d;
  logic [1:0]                  wr_be_q, wr_be_d;
  logic [3*BITDEPTH_MAX-1:0]   wr_data_q, wr_data_d;
  logic                        overrun_q, overrun_d, sync_err_q, sync_err_d;
  logic                        frame_done_q, frame_done_d;

  // Geometry used by the current beat: live inputs while idle, latched copy otherwise.
  logic [CTRL_REG_WIDTH-1:0]   n_rows_e, n_cols_e, bitdepth_e;
  logic [CTRL_REG_WIDTH-1:0]   cur_row, cur_col, half, row_in_half;
  logic                        last_col, last_row, top_lane, do_write;
  logic [3*BITDEPTH_MAX-1:0]   planes;
  logic [2:0]                  idx;
  logic [7:0]                  ch_r, ch_g, ch_b;

  assign n_rows_e    = (state_q == StIdle) ? ctrl_n_rows   : n_rows_q;
  assign n_cols_e    = (state_q == StIdle) ? ctrl_n_cols   : n_cols_q;
  assign bitdepth_e  = (state_q == StIdle) ? ctrl_bitdepth : bitdepth_q;
  assign cur_row     = s_sof ? '0 : row_q;
  assign cur_col     = s_sof ? '0 : col_q;
  assign last_col    = (cur_col == n_cols_e - One);
  assign last_row    = (cur_row == n_rows_e - One);
  assign half        = n_rows_e >> 1;
  assign top_lane    = (cur_row < half);
  assign row_in_half = top_lane ? cur_row : cur_row - half;
  assign ch_r        = s_pixel[23:16];
  assign ch_g        = s_pixel[15:8];
  assign ch_b        = s_pixel[7:0];

  assign s_ready = ctrl_en && !ctrl_rst && (state_q == StIdle || state_q == StWrite);
  // Only SOF beats start a frame; other beats offered while idle are dropped.
  assign do_write = s_valid && s_ready && (state_q == StWrite || s_sof);

  // The top bit-planes carry the channel MSBs; planes beyond bitdepth stay zero.
  always_comb begin
    planes = '0;
    idx    = '0;
    for (int p = 0; p < BITDEPTH_MAX; p++) begin
      if (CTRL_REG_WIDTH'(p) < bitdepth_e) begin
        idx = 3'(CTRL_REG_WIDTH'(8) - bitdepth_e + CTRL_REG_WIDTH'(p));
        planes[3*p+2] = ch_r[idx];
        planes[3*p+1] = ch_g[idx];
        planes[3*p]   = ch_b[idx];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    n_rows_d     = n_rows_q;
    n_cols_d     = n_cols_q;
    bitdepth_d   = bitdepth_q;
    row_d        = row_q;
    col_d        = col_q;
    wr_buffer_d  = wr_buffer_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_be_d      = wr_be_q;
    wr_data_d    = wr_data_q;
    overrun_d    = overrun_q;
    sync_err_d   = sync_err_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (do_write) begin
          n_rows_d    = ctrl_n_rows;
          n_cols_d    = ctrl_n_cols;
          bitdepth_d  = ctrl_bitdepth;
          wr_buffer_d = ~rd_buffer;
        end
      end
      StWrite: begin
        if (rd_buffer == wr_buffer_q) overrun_d = 1'b1;
        if (do_write && s_sof) sync_err_d = 1'b1;
      end
      StHandoff: begin
        if (ctrl_en && rd_buffer == wr_buffer_q) begin
          frame_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_write) begin
      wr_en_d   = 1'b1;
      wr_addr_d = ADDR_WIDTH'(row_in_half * n_cols_e + cur_col);
      wr_be_d   = top_lane ? 2'b10 : 2'b01;
      wr_data_d = planes;
      // Addressing follows the column count; s_eol only feeds the error flag.
      if (s_eol != last_col) sync_err_d = 1'b1;
      if (last_col) begin
        col_d = '0;
        row_d = cur_row + One;
      end else begin
        col_d = cur_col + One;
        row_d = cur_row;
      end
      state_d = (last_col && last_row) ? StHandoff : StWrite;
    end

    if (!ctrl_en) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (ctrl_rst) begin
      state_q      <= StIdle;
      n_rows_q     <= '0;
      n_cols_q     <= '0;
      bitdepth_q   <= '0;
      row_q        <= '0;
      col_q        <= '0;
      wr_buffer_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_be_q      <= '0;
      wr_data_q    <= '0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_rows_q     <= n_rows_d;
      n_cols_q     <= n_cols_d;
      bitdepth_q   <= bitdepth_d;
      row_q        <= row_d;
      col_q        <= col_d;
      wr_buffer_q  <= wr_buffer_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_be_q      <= wr_be_d;
      wr_data_q    <= wr_data_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_en           = wr_en_q;
  assign wr_buffer       = wr_buffer_q;
  assign wr_addr         = wr_addr_q;
  assign wr_be           = wr_be_q;
  assign wr_data         = wr_data_q;
  assign status_overrun  = overrun_q;
  assign status_sync_err = sync_err_q;
  assign frame_done      = frame_done_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed frames plus randomized traffic scored
// against a pixel-index reference model.
module tb_pixel_writer;
  localparam int W  = 32;
  localparam int AW = 13;
  localparam int BD = 8;

  logic          clk = 1'b0;
  logic          ctrl_rst, ctrl_en;
  logic [W-1:0]  ctrl_n_rows, ctrl_n_cols, ctrl_bitdepth;
  logic [23:0]   s_pixel;
  logic          s_valid, s_ready, s_sof, s_eol, rd_buffer;
  logic          wr_en, wr_buffer, status_overrun, status_sync_err, frame_done;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_be;
  logic [3*BD-1:0] wr_data;

  always #5 clk = ~clk;

  pixel_writer dut (
    .clk(clk), .ctrl_rst(ctrl_rst), .ctrl_en(ctrl_en),
    .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols), .ctrl_bitdepth(ctrl_bitdepth),
    .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_eol(s_eol),
    .rd_buffer(rd_buffer), .wr_en(wr_en), .wr_buffer(wr_buffer), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .status_overrun(status_overrun),
    .status_sync_err(status_sync_err), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame phase (0 idle, 1 writing, 2 waiting for display) and pixel index k.
  int         m_phase = 0, m_k = 0, m_nr = 1, m_nc = 1, m_bd = 8;
  bit         m_buf = 0, m_ovr = 0, m_serr = 0, m_acc = 0;
  bit         e_wr_en = 0, e_fd = 0;
  logic [AW-1:0] e_addr = '0;
  logic [1:0]    e_be = '0;
  logic [23:0]   e_data = '0;

  int          log_addr[$];
  int          log_be[$];
  logic [23:0] log_data[$];

  function automatic logic [23:0] plane_word(input logic [23:0] pix, input int bd);
    logic [23:0] d = '0;
    for (int p = 0; p < BD; p++) begin
      if (p < bd) begin
        int s = 8 - bd + p;
        d[3*p+2] = pix[16+s];
        d[3*p+1] = pix[8+s];
        d[3*p]   = pix[s];
      end
    end
    return d;
  endfunction

  // Predicts the effect of the coming clock edge from the inputs currently applied.
  task automatic model_step();
    bit ready;
    int row, col;
    e_wr_en = 0;
    e_fd    = 0;
    m_acc   = 0;
    if (ctrl_rst) begin
      m_phase = 0; m_k = 0; m_buf = 0; m_ovr = 0; m_serr = 0;
      return;
    end
    ready = ctrl_en && m_phase != 2;
    m_acc = s_valid && ready;
    if (m_phase == 1 && rd_buffer == m_buf) m_ovr = 1;
    if (m_phase == 2 && ctrl_en && rd_buffer == m_buf) begin
      e_fd = 1;
      m_phase = 0;
    end
    if (m_acc && (m_phase == 1 || s_sof)) begin
      if (m_phase == 0) begin
        m_nr = int'(ctrl_n_rows); m_nc = int'(ctrl_n_cols); m_bd = int'(ctrl_bitdepth);
        m_buf = ~rd_buffer;
      end else if (s_sof) begin
        m_serr = 1;
      end
      if (s_sof) m_k = 0;
      row = m_k / m_nc;
      col = m_k % m_nc;
      if ((col == m_nc - 1) != s_eol) m_serr = 1;
      e_wr_en = 1;
      if (row < m_nr / 2) begin
        e_be = 2'b10; e_addr = AW'(row * m_nc + col);
      end else begin
        e_be = 2'b01; e_addr = AW'((row - m_nr / 2) * m_nc + col);
      end
      e_data = plane_word(s_pixel, m_bd);
      m_k++;
      m_phase = (m_k == m_nr * m_nc) ? 2 : 1;
    end
    if (!ctrl_en) m_phase = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_eq("s_ready", s_ready, (!ctrl_rst && ctrl_en && m_phase != 2));
    check_eq("wr_en", wr_en, e_wr_en);
    if (e_wr_en) begin
      check_eq("wr_addr", wr_addr, e_addr);
      check_eq("wr_be", wr_be, e_be);
      check_eq("wr_data", wr_data, e_data);
    end
    check_eq("wr_buffer", wr_buffer, m_buf);
    check_eq("frame_done", frame_done, e_fd);
    check_eq("status_overrun", status_overrun, m_ovr);
    check_eq("status_sync_err", status_sync_err, m_serr);
    if (wr_en) begin
      log_addr.push_back(int'(wr_addr));
      log_be.push_back(int'(wr_be));
      log_data.push_back(wr_data);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [23:0] pix, input bit sof, input bit eol);
    bit done = 0;
    s_pixel = pix; s_sof = sof; s_eol = eol; s_valid = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      cycle();
      done = m_acc;
    end
    check_eq("beat_accepted", done, 1);
    s_valid = 0; s_sof = 0; s_eol = 0;
  endtask

  task automatic set_geom(input int nr, input int nc, input int bd);
    ctrl_n_rows = W'(nr); ctrl_n_cols = W'(nc); ctrl_bitdepth = W'(bd);
  endtask

  task automatic frame_4x2(input bit eol_at_col0);
    int exp_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_b[8] = '{2, 2, 2, 2, 1, 1, 1, 1};
    log_addr.delete(); log_be.delete(); log_data.delete();
    set_geom(4, 2, 8);
    for (int i = 0; i < 8; i++)
      beat(24'($urandom), i == 0, eol_at_col0 ? (i % 2 == 0) : (i % 2 == 1));
    cycle();
    check_eq("n_writes", log_addr.size(), 8);
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      check_eq("seq_addr", log_addr[i], exp_a[i]);
      check_eq("seq_be", log_be[i], exp_b[i]);
    end
    check_eq("ready_after_frame", s_ready, 0);
  endtask

  initial begin
    int sz;
    ctrl_rst = 1; ctrl_en = 1; rd_buffer = 0;
    set_geom(4, 2, 8);
    s_pixel = '0; s_valid = 0; s_sof = 0; s_eol = 0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    ctrl_rst = 0;
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_buffer", wr_buffer, 0);
    check_eq("rst_flags", {status_overrun, status_sync_err, frame_done}, 0);

    // Clean 4x2 frame into buffer 1, then display flips to it.
    frame_4x2(0);
    check_eq("frame1_buffer", wr_buffer, 1);
    check_eq("frame1_sync", status_sync_err, 0);
    rd_buffer = 1;
    cycle();
    cycle();
    check_eq("idle_after_done", s_ready, 1);

    // Misplaced s_eol: flag raised, addressing unchanged, buffer 0 now.
    frame_4x2(1);
    check_eq("frame2_buffer", wr_buffer, 0);
    check_eq("frame2_sync", status_sync_err, 1);
    rd_buffer = 0;
    cycle();
    cycle();

    // 4-bit planes of a single-pixel frame.
    set_geom(1, 1, 4);
    beat(24'hF0A50F, 1, 1);
    cycle();
    check_eq("bd4_data", log_data[log_data.size()-1], 24'h000D34);
    rd_buffer = 1;
    cycle();
    cycle();

    // Display catches the writer mid-frame, then reset discards the frame.
    set_geom(4, 2, 8);
    beat(24'h123456, 1, 0);
    beat(24'h654321, 0, 1);
    rd_buffer = 0;
    cycle();
    cycle();
    check_eq("overrun_set", status_overrun, 1);
    ctrl_rst = 1;
    cycle();
    ctrl_rst = 0;
    check_eq("mid_rst_wr_en", wr_en, 0);
    check_eq("mid_rst_flags", {status_overrun, status_sync_err}, 0);
    sz = log_addr.size();
    beat(24'hABCDEF, 0, 0);
    beat(24'hFEDCBA, 0, 1);
    cycle();
    check_eq("no_sof_dropped", log_addr.size(), sz);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int nc_eff, col_next;
      ctrl_rst = ($urandom % 250 == 0);
      ctrl_en  = ($urandom % 60 != 0);
      if ($urandom % 30 == 0)
        set_geom(1 + $urandom % 6, 1 + $urandom % 5, 1 + $urandom % 8);
      s_valid  = ($urandom % 4 != 0);
      s_pixel  = 24'($urandom);
      nc_eff   = (m_phase == 1) ? m_nc : int'(ctrl_n_cols);
      col_next = (m_phase == 1) ? m_k % m_nc : 0;
      s_sof    = (m_phase == 1) ? ($urandom % 60 == 0) : ($urandom % 3 == 0);
      s_eol    = (col_next == nc_eff - 1) ^ ($urandom % 25 == 0);
      if (m_phase == 2 && $urandom % 3 == 0) rd_buffer = m_buf;
      else if ($urandom % 80 == 0) rd_buffer = ~rd_buffer;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
